tlul_host_seq: RTL and testbench

Synthesizable TL-UL host sequencer that issues a parametrised list of transactions (writes and checked reads) on one TL-UL host port after a programmable start delay. It is the reusable successor to fixed single-write stimulus logic in the RoT simulation top. Typical uses are keymgr/entropy bring-up sequences and self-test of rot_top crossbar targets. It runs one outstanding transaction at a time, checks every response, and reports done, error and the failing index.

---
 rtl/tlul_host_seq_pkg.sv | 49 ++++
 rtl/tlul_host_seq.sv | 162 ++++++++++++++++
 tb/tb_tlul_host_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlul_host_seq_pkg.sv
// Shared types for the TL-UL host sequencer: sequence entries, error codes, FSM states
// and the minimal TL-UL channel structs used by the RoT simulation top.
package tlul_host_seq_pkg;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        logic [31:0] mask;
    } seq_op_t;

    typedef enum logic [1:0] {ErrNone, ErrDErr, ErrMismatch, ErrTimeout} err_code_e;

    typedef enum logic [2:0] {StIdle, StDelay, StReq, StRsp, StDone, StErr} state_e;

    localparam logic [2:0]  PutFullData        = 3'h0;
    localparam logic [2:0]  Get                = 3'h4;
    localparam logic [13:0] TL_A_USER_DEFAULT  = 14'h0240;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [13:0] a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [6:0]  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    localparam tl_h2d_t TL_H2D_DEFAULT = '{a_user: TL_A_USER_DEFAULT, default: '0};

endpackage

// File: rtl/tlul_host_seq.sv
// TL-UL host sequencer: after a start delay, issues a table of writes and checked reads,
// one outstanding at a time, and reports done/error with the failing index.
module tlul_host_seq
    import tlul_host_seq_pkg::*;
#(
    parameter int unsigned NumOps        = 4,
    parameter int unsigned DelayW        = 12,
    parameter int unsigned TimeoutCycles = 256,
    parameter int unsigned IdxW          = (NumOps > 1) ? $clog2(NumOps) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [DelayW-1:0]      delay_i,
    input  seq_op_t [NumOps-1:0]   ops_i,
    output tl_h2d_t                tl_o,
    input  tl_d2h_t                tl_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [IdxW-1:0]        err_idx_o,
    output logic [1:0]             err_code_o,
    output logic [31:0]            rdata_o
);

    localparam int unsigned     TmoW    = $clog2(TimeoutCycles);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumOps - 1);

    state_e            state_q;
    logic [DelayW-1:0] dly_q;
    logic [TmoW-1:0]   tmo_q;
    logic [IdxW-1:0]   idx_q;
    logic [IdxW-1:0]   idx_nxt;
    seq_op_t           cur_op;
    logic              fail;
    err_code_e         fail_code;

    function automatic tl_h2d_t req_for(seq_op_t op, logic [IdxW-1:0] idx);
        tl_h2d_t req;
        req           = TL_H2D_DEFAULT;
        req.a_valid   = 1'b1;
        req.a_opcode  = op.write ? PutFullData : Get;
        req.a_size    = 2'd2;
        req.a_mask    = 4'hF;
        req.a_source  = 8'(idx);
        req.a_address = op.addr;
        req.a_data    = op.write ? op.data : 32'h0;
        return req;
    endfunction

    assign idx_nxt = idx_q + IdxW'(1);
    assign cur_op  = ops_i[idx_q];

    // A handshake and d_valid take priority over a timeout landing in the same cycle.
    always_comb begin
        fail      = 1'b0;
        fail_code = ErrNone;
        if (state_q == StReq) begin
            if (!tl_i.a_ready && tmo_q == TmoLast) begin
                fail      = 1'b1;
                fail_code = ErrTimeout;
            end
        end else if (state_q == StRsp) begin
            if (tl_i.d_valid) begin
                if (tl_i.d_error) begin
                    fail      = 1'b1;
                    fail_code = ErrDErr;
                end else if (!cur_op.write &&
                             ((tl_i.d_data & cur_op.mask) != (cur_op.exp & cur_op.mask))) begin
                    fail      = 1'b1;
                    fail_code = ErrMismatch;
                end
            end else if (tmo_q == TmoLast) begin
                fail      = 1'b1;
                fail_code = ErrTimeout;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            tl_o       <= TL_H2D_DEFAULT;
            dly_q      <= '0;
            tmo_q      <= '0;
            idx_q      <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_idx_o  <= '0;
            err_code_o <= ErrNone;
            rdata_o    <= '0;
        end else if (fail) begin
            // ERR keeps d_ready high so a late response is drained.
            state_q      <= StErr;
            tl_o.a_valid <= 1'b0;
            tl_o.d_ready <= 1'b1;
            busy_o       <= 1'b0;
            err_o        <= 1'b1;
            err_code_o   <= fail_code;
            err_idx_o    <= idx_q;
        end else begin
            unique case (state_q)
                StIdle, StDone, StErr: begin
                    if (start_i) begin
                        state_q    <= StDelay;
                        tl_o       <= TL_H2D_DEFAULT;
                        busy_o     <= 1'b1;
                        done_o     <= 1'b0;
                        err_o      <= 1'b0;
                        err_code_o <= ErrNone;
                        err_idx_o  <= '0;
                        dly_q      <= '0;
                        idx_q      <= '0;
                    end
                end
                StDelay: begin
                    if (dly_q == delay_i) begin
                        state_q <= StReq;
                        tl_o    <= req_for(cur_op, idx_q);
                        tmo_q   <= '0;
                    end else if (dly_q != '1) begin
                        dly_q <= dly_q + DelayW'(1);
                    end
                end
                StReq: begin
                    if (tl_i.a_ready) begin
                        state_q      <= StRsp;
                        tl_o.a_valid <= 1'b0;
                        tl_o.d_ready <= 1'b1;
                        tmo_q        <= '0;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
                StRsp: begin
                    if (tl_i.d_valid) begin
                        if (!cur_op.write) begin
                            rdata_o <= tl_i.d_data;
                        end
                        if (idx_q == LastIdx) begin
                            state_q      <= StDone;
                            tl_o.d_ready <= 1'b0;
                            busy_o       <= 1'b0;
                            done_o       <= 1'b1;
                        end else begin
                            state_q <= StReq;
                            idx_q   <= idx_nxt;
                            tl_o    <= req_for(ops_i[idx_nxt], idx_nxt);
                            tmo_q   <= '0;
                        end
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_tlul_host_seq.sv
// Self-checking bench for tlul_host_seq: directed table, randomized sequences against a
// behavioural outcome model, and hand-written start-delay and reset corner cases.
module tb_tlul_host_seq;
    import tlul_host_seq_pkg::*;

    localparam int T = 16;
    localparam logic [31:0] ADDR_SPACE_KEYMGR_ROT          = 32'h4114_0000;
    localparam logic [31:0] KEYMGR_CONTROL_SHADOWED_OFFSET = 32'h0000_0014;

    typedef struct packed {
        seq_op_t [3:0]    op;
        logic [3:0][5:0]  rh;
        logic [3:0][5:0]  sh;
        logic [3:0]       de;
        logic [3:0][31:0] rd;
        logic [3:0]       delay;
        logic             exp_done;
        logic [1:0]       exp_code;
        logic [1:0]       exp_idx;
        logic [31:0]      exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [3:0]    delay = '0;
    seq_op_t [3:0] ops = '0;
    tl_h2d_t       tl_o_m;
    tl_d2h_t       tl_i_m = '0;
    logic          busy, done, err;
    logic [1:0]    err_idx, err_code;
    logic [31:0]   rdata;

    logic          start1 = 1'b0;
    logic [11:0]   delay1 = '0;
    seq_op_t [0:0] ops1 = '0;
    tl_h2d_t       tl_o_1;
    tl_d2h_t       tl_i_1 = '0;
    logic          busy1, done1, err1;
    logic [0:0]    err_idx1;
    logic [1:0]    err_code1;
    logic [31:0]   rdata1;

    tlul_host_seq #(.NumOps(4), .DelayW(4), .TimeoutCycles(T)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .delay_i(delay), .ops_i(ops),
        .tl_o(tl_o_m), .tl_i(tl_i_m), .busy_o(busy), .done_o(done), .err_o(err),
        .err_idx_o(err_idx), .err_code_o(err_code), .rdata_o(rdata)
    );

    tlul_host_seq #(.NumOps(1), .DelayW(12), .TimeoutCycles(256)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .delay_i(delay1), .ops_i(ops1),
        .tl_o(tl_o_1), .tl_i(tl_i_1), .busy_o(busy1), .done_o(done1), .err_o(err1),
        .err_idx_o(err_idx1), .err_code_o(err_code1), .rdata_o(rdata1)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] model_rdata;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic seq_op_t wr(logic [31:0] a, logic [31:0] d);
        return '{write: 1'b1, addr: a, data: d, exp: 32'h0, mask: 32'h0};
    endfunction

    function automatic seq_op_t rdop(logic [31:0] a, logic [31:0] e, logic [31:0] m);
        return '{write: 1'b0, addr: a, data: 32'h0, exp: e, mask: m};
    endfunction

    // Outcome straight from the sequencing rules: first op that times out, errors or mismatches.
    function automatic vec_t predict(vec_t v, logic [31:0] prev_rdata);
        int c;
        v.exp_done  = 1'b1;
        v.exp_code  = 2'd0;
        v.exp_idx   = 2'd0;
        v.exp_rdata = prev_rdata;
        for (int i = 0; i < 4; i++) begin
            c = 0;
            if (int'(v.rh[i]) >= T || int'(v.sh[i]) >= T) c = 3;
            else if (v.de[i]) c = 1;
            else if (!v.op[i].write && ((v.rd[i] ^ v.op[i].exp) & v.op[i].mask) != 0) c = 2;
            if (c != 0) begin
                v.exp_done = 1'b0;
                v.exp_code = 2'(c);
                v.exp_idx  = 2'(i);
                return v;
            end
            if (!v.op[i].write) v.exp_rdata = v.rd[i];
        end
        return v;
    endfunction

    task automatic run_seq(input vec_t v, input bit glitch);
        int lat;
        int hold;
        bit term;
        bit fails;
        tl_h2d_t snap;
        ops   = v.op;
        delay = v.delay;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_at_start", busy, 1);
        chk("done_cleared", done, 0);
        chk("err_cleared", err, 0);
        lat = 1;
        while (!tl_o_m.a_valid && lat < 40) begin
            start = glitch && (lat == 1);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("req_latency", lat, v.delay + 2);
        term = 1'b0;
        for (int i = 0; i < 4 && !term; i++) begin
            fails = !v.exp_done && (i == int'(v.exp_idx));
            chk("a_valid", tl_o_m.a_valid, 1);
            if (!tl_o_m.a_valid) begin
                term = 1'b1;
            end else begin
                chk("a_source", tl_o_m.a_source, i);
                chk("a_opcode", tl_o_m.a_opcode, v.op[i].write ? 3'h0 : 3'h4);
                chk("a_address", tl_o_m.a_address, v.op[i].addr);
                chk("a_data", tl_o_m.a_data, v.op[i].write ? v.op[i].data : 32'h0);
                chk("a_size_mask", {tl_o_m.a_size, tl_o_m.a_mask}, {2'd2, 4'hF});
                chk("d_ready_req", tl_o_m.d_ready, 0);
                snap = tl_o_m;
                hold = (int'(v.rh[i]) >= T) ? T : int'(v.rh[i]);
                for (int n = 1; n <= hold; n++) begin
                    @(negedge clk);
                    if (n < T) chk("a_stable", tl_o_m, snap);
                end
                if (int'(v.rh[i]) >= T) begin
                    chk("a_drop_on_timeout", tl_o_m.a_valid, 0);
                    term = 1'b1;
                end else begin
                    tl_i_m.a_ready = 1'b1;
                    @(negedge clk);
                    tl_i_m.a_ready = 1'b0;
                    chk("a_valid_low_in_rsp", tl_o_m.a_valid, 0);
                    chk("d_ready_rsp", tl_o_m.d_ready, 1);
                    hold = (int'(v.sh[i]) >= T) ? T : int'(v.sh[i]);
                    for (int n = 1; n <= hold; n++) @(negedge clk);
                    if (int'(v.sh[i]) >= T) begin
                        tl_i_m.d_valid = 1'b1;
                        @(negedge clk);
                        tl_i_m.d_valid = 1'b0;
                        chk("late_rsp_d_ready", tl_o_m.d_ready, 1);
                        term = 1'b1;
                    end else begin
                        tl_i_m.d_valid  = 1'b1;
                        tl_i_m.d_data   = v.rd[i];
                        tl_i_m.d_error  = v.de[i];
                        tl_i_m.d_source = 8'(i);
                        @(negedge clk);
                        tl_i_m.d_valid = 1'b0;
                        tl_i_m.d_error = 1'b0;
                        if (fails || i == 3) term = 1'b1;
                    end
                end
            end
        end
        chk("busy_end", busy, 0);
        chk("done", done, v.exp_done);
        chk("err", err, !v.exp_done);
        chk("err_code", err_code, v.exp_code);
        chk("err_idx", err_idx, v.exp_idx);
        chk("rdata", rdata, v.exp_rdata);
        repeat (3) @(negedge clk);
        chk("no_extra_req", tl_o_m.a_valid, 0);
    endtask

    initial begin
        int lat;
        vec_t v;

        vecs[0] = '0;
        vecs[0].op[0] = wr(32'h1000, 32'h1111_1111);
        vecs[0].op[1] = rdop(32'h1004, 32'hA5A5_FFFF, 32'hFFFF_0000);
        vecs[0].op[2] = wr(32'h1008, 32'h22);
        vecs[0].op[3] = rdop(32'h100C, 32'hA5A5_FFFF, 32'hFFFF_0000);
        vecs[0].rh[0] = 6'd10;
        vecs[0].sh[3] = 6'd2;
        vecs[0].rd[1] = 32'hA5A5_0000;
        vecs[0].rd[3] = 32'hA5A5_0000;
        vecs[0].delay = 4'd3;
        vecs[0].exp_done = 1'b1;
        vecs[0].exp_rdata = 32'hA5A5_0000;

        vecs[1] = '0;
        vecs[1].op[0] = wr(32'h2000, 32'h1);
        vecs[1].op[1] = wr(32'h2004, 32'h2);
        vecs[1].op[2] = rdop(32'h2008, 32'h0, 32'hFFFF_FFFF);
        vecs[1].op[3] = wr(32'h200C, 32'h3);
        vecs[1].rd[2] = 32'h1;
        vecs[1].delay = 4'd1;
        vecs[1].exp_code = 2'd2;
        vecs[1].exp_idx = 2'd2;
        vecs[1].exp_rdata = 32'hA5A5_0000;

        vecs[2] = '0;
        vecs[2].op[0] = wr(32'h3000, 32'hDEAD_BEEF);
        vecs[2].op[1] = wr(32'h3004, 32'h5);
        vecs[2].de[0] = 1'b1;
        vecs[2].exp_code = 2'd1;
        vecs[2].exp_idx = 2'd0;
        vecs[2].exp_rdata = 32'hA5A5_0000;

        vecs[3] = '0;
        vecs[3].op[0] = rdop(32'h3100, 32'h0, 32'h0);
        vecs[3].op[1] = wr(32'h3104, 32'h6);
        vecs[3].rd[0] = 32'h1234_5678;
        vecs[3].sh[1] = 6'(T);
        vecs[3].delay = 4'd2;
        vecs[3].exp_code = 2'd3;
        vecs[3].exp_idx = 2'd1;
        vecs[3].exp_rdata = 32'h1234_5678;

        vecs[4] = '0;
        vecs[4].op[0] = wr(32'h3200, 32'h7);
        vecs[4].op[1] = wr(32'h3204, 32'h8);
        vecs[4].op[2] = rdop(32'h3208, 32'h0, 32'hFFFF_FFFF);
        vecs[4].rh[2] = 6'(T);
        vecs[4].delay = 4'd15;
        vecs[4].exp_code = 2'd3;
        vecs[4].exp_idx = 2'd2;
        vecs[4].exp_rdata = 32'h1234_5678;

        vecs[5] = '0;
        vecs[5].op[0] = wr(32'h4000, 32'h9);
        vecs[5].op[1] = wr(32'h4004, 32'hA);
        vecs[5].op[2] = wr(32'h4008, 32'hB);
        vecs[5].op[3] = rdop(32'h400C, 32'hCAFE_F00D, 32'hFFFF_FFFF);
        vecs[5].rh[0] = 6'(T - 1);
        vecs[5].sh[0] = 6'(T - 1);
        vecs[5].rd[3] = 32'hCAFE_F00D;
        vecs[5].exp_done = 1'b1;
        vecs[5].exp_rdata = 32'hCAFE_F00D;

        repeat (3) @(negedge clk);
        chk("rst_tl_o", tl_o_m, TL_H2D_DEFAULT);
        chk("rst_flags", {busy, done, err, err_idx, err_code}, 0);
        chk("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single keymgr write after a long start delay on the one-entry instance.
        ops1[0] = wr(ADDR_SPACE_KEYMGR_ROT + KEYMGR_CONTROL_SHADOWED_OFFSET, 32'h12);
        delay1  = 12'd1500;
        start1  = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 1;
        while (!tl_o_1.a_valid && lat < 1600) begin
            @(negedge clk);
            lat++;
        end
        chk("t1_latency", lat, 1502);
        chk("t1_opcode", tl_o_1.a_opcode, 3'h0);
        chk("t1_data", tl_o_1.a_data, 32'h12);
        chk("t1_addr", tl_o_1.a_address, ADDR_SPACE_KEYMGR_ROT + KEYMGR_CONTROL_SHADOWED_OFFSET);
        tl_i_1.a_ready = 1'b1;
        @(negedge clk);
        tl_i_1.a_ready = 1'b0;
        tl_i_1.d_valid = 1'b1;
        @(negedge clk);
        tl_i_1.d_valid = 1'b0;
        chk("t1_done", {done1, err1, busy1}, 3'b100);

        for (int k = 0; k < 6; k++) begin
            run_seq(vecs[k], k == 0);
        end
        model_rdata = 32'hCAFE_F00D;

        for (int r = 0; r < 24; r++) begin
            v = '0;
            v.delay = 4'($urandom_range(0, 5));
            for (int i = 0; i < 4; i++) begin
                v.op[i].write = 1'($urandom_range(0, 1));
                v.op[i].addr  = $urandom;
                v.op[i].data  = $urandom;
                v.op[i].exp   = $urandom;
                case ($urandom_range(0, 2))
                    0: v.op[i].mask = 32'h0;
                    1: v.op[i].mask = 32'hFFFF_FFFF;
                    default: v.op[i].mask = $urandom;
                endcase
                v.rd[i] = ($urandom_range(0, 3) != 0) ?
                          (v.op[i].exp ^ ($urandom & ~v.op[i].mask)) : $urandom;
                v.rh[i] = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(T - 1, T)) :
                                                         6'($urandom_range(0, 3));
                v.sh[i] = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(T - 1, T)) :
                                                         6'($urandom_range(0, 3));
                v.de[i] = ($urandom_range(0, 15) == 0);
            end
            v = predict(v, model_rdata);
            run_seq(v, 1'b0);
            model_rdata = v.exp_rdata;
        end

        // Reset while waiting for a response.
        ops   = vecs[0].op;
        delay = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!tl_o_m.a_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("rst_seq_req", tl_o_m.a_valid, 1);
        tl_i_m.a_ready = 1'b1;
        @(negedge clk);
        tl_i_m.a_ready = 1'b0;
        chk("rst_seq_in_rsp", tl_o_m.d_ready, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_tl_o", tl_o_m, TL_H2D_DEFAULT);
        chk("async_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", {tl_o_m.a_valid, busy, done, err}, 0);
        chk("post_rst_rdata", rdata, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
